// File: rtl/cpu_eu_pkg.sv
// Shared definitions for the execution-unit block-move sequencer:
// state encoding, default data width, address-mux codes, timer sizing helper.
package cpu_eu_pkg;

    localparam int DW_DEF = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_RD   = 3'd2;
    localparam state_t ST_WR   = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    localparam logic ADDR_SEL_A = 1'b0;
    localparam logic ADDR_SEL_B = 1'b1;

    // Wait timer must be able to hold WAIT_LIMIT itself; a disabled timer still needs one bit.
    function automatic int timer_width(input int unsigned limit);
        if (limit > 32'd0) begin
            return $clog2(limit + 32'd1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/eu_block_move_ctrl_if.sv
// Control-unit and memory-port bundle of the block-move sequencer.
// master = sequencer side, slave = CPU control unit / memory / pointer registers side.
interface eu_block_move_ctrl_if
    import cpu_eu_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          start;
    logic          abort;
    logic [DW-1:0] src_addr;
    logic [DW-1:0] dst_addr;
    logic [DW-1:0] count;
    logic [DW-1:0] ptr_a_din;
    logic          ptr_a_ld;
    logic          ptr_a_inc;
    logic [DW-1:0] ptr_b_din;
    logic          ptr_b_ld;
    logic          ptr_b_inc;
    logic          addr_sel;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;
    logic          done;
    logic          error;
    logic [DW-1:0] remaining;

    modport master (
        input  start, abort, src_addr, dst_addr, count, mem_rdata, mem_ack,
        output ptr_a_din, ptr_a_ld, ptr_a_inc, ptr_b_din, ptr_b_ld, ptr_b_inc,
               addr_sel, mem_req, mem_we, mem_wdata, busy, done, error, remaining
    );

    modport slave (
        output start, abort, src_addr, dst_addr, count, mem_rdata, mem_ack,
        input  ptr_a_din, ptr_a_ld, ptr_a_inc, ptr_b_din, ptr_b_ld, ptr_b_inc,
               addr_sel, mem_req, mem_we, mem_wdata, busy, done, error, remaining
    );

endinterface

// File: rtl/eu_down_counter.sv
// Loadable down counter with zero flag; load wins over decrement.
// Callers gate dec with !zero so the count never wraps below 0.
module eu_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] cnt_r;

    // Count register: load has priority, then decrement, else hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign value = cnt_r;
    assign zero  = (cnt_r == '0);

endmodule

// File: rtl/eu_block_move_ctrl.sv
// Block-move sequencer: loads source/destination pointers, then alternates
// read @A / write @B per word, incrementing both pointers after each write.
module eu_block_move_ctrl
    import cpu_eu_pkg::*;
#(
    parameter int          DW         = DW_DEF,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input logic                  clk,
    input logic                  reset,
    eu_block_move_ctrl_if.master bus
);
    localparam int              TW       = timer_width(WAIT_LIMIT);
    localparam logic [TW-1:0]   TMR_INIT = TW'(WAIT_LIMIT);

    state_t        state_r;
    state_t        state_s;
    logic [DW-1:0] src_r;
    logic [DW-1:0] dst_r;
    logic [DW-1:0] rdata_r;
    logic [DW-1:0] rem_val_s;
    logic          rem_zero_s;
    logic [TW-1:0] tmr_val_unused_s;
    logic          tmr_zero_s;
    logic          start_ok_s;
    logic          capture_s;
    logic          rd_ack_s;
    logic          wr_ack_s;
    logic          waiting_s;
    logic          timeout_s;
    logic          last_s;
    logic          ld_s;
    logic          inc_s;
    logic          req_s;
    logic          we_s;
    logic          addr_sel_s;
    logic          busy_s;
    logic          done_s;

    assign start_ok_s = (state_r == ST_IDLE) && bus.start;
    assign capture_s  = start_ok_s && (bus.count != '0);
    assign rd_ack_s   = (state_r == ST_RD) && bus.mem_ack;
    assign wr_ack_s   = (state_r == ST_WR) && bus.mem_ack;
    assign waiting_s  = ((state_r == ST_RD) || (state_r == ST_WR)) && !bus.mem_ack;
    // Timer is reloaded whenever not stalling, so it only expires after WAIT_LIMIT back-to-back stall cycles.
    assign timeout_s  = (WAIT_LIMIT != 32'd0) && waiting_s && tmr_zero_s;
    assign last_s     = (rem_val_s == DW'(1));

    eu_down_counter #(.W(DW)) u_remaining (
        .clk      (clk),
        .reset    (reset),
        .load     (start_ok_s),
        .load_val (bus.count),
        .dec      (wr_ack_s && !rem_zero_s),
        .value    (rem_val_s),
        .zero     (rem_zero_s)
    );

    eu_down_counter #(.W(TW)) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (!waiting_s),
        .load_val (TMR_INIT),
        .dec      (waiting_s && !tmr_zero_s),
        .value    (tmr_val_unused_s),
        .zero     (tmr_zero_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Captured start addresses and the word read on the last RD beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_r   <= '0;
            dst_r   <= '0;
            rdata_r <= '0;
        end else begin
            if (capture_s) begin
                src_r <= bus.src_addr;
                dst_r <= bus.dst_addr;
            end else begin
                src_r <= src_r;
                dst_r <= dst_r;
            end
            if (rd_ack_s) begin
                rdata_r <= bus.mem_rdata;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Next-state logic; abort outranks ack and timeout, ack outranks timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = (bus.count != '0) ? ST_LOAD : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = bus.abort ? ST_IDLE : ST_RD;
            end
            ST_RD: begin
                if (bus.abort || timeout_s) begin
                    state_s = ST_IDLE;
                end else if (bus.mem_ack) begin
                    state_s = ST_WR;
                end else begin
                    state_s = ST_RD;
                end
            end
            ST_WR: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else if (bus.mem_ack) begin
                    state_s = last_s ? ST_DONE : ST_RD;
                end else if (timeout_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WR;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from state and mem_ack, no extra latency.
    always_comb begin
        ld_s       = 1'b0;
        inc_s      = 1'b0;
        req_s      = 1'b0;
        we_s       = 1'b0;
        addr_sel_s = ADDR_SEL_A;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_LOAD: begin
                ld_s   = 1'b1;
                busy_s = 1'b1;
            end
            ST_RD: begin
                req_s  = 1'b1;
                busy_s = 1'b1;
            end
            ST_WR: begin
                req_s      = 1'b1;
                we_s       = 1'b1;
                addr_sel_s = ADDR_SEL_B;
                busy_s     = 1'b1;
                inc_s      = bus.mem_ack;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                ld_s = 1'b0;
            end
        endcase
    end

    assign bus.ptr_a_din = src_r;
    assign bus.ptr_b_din = dst_r;
    assign bus.ptr_a_ld  = ld_s;
    assign bus.ptr_b_ld  = ld_s;
    assign bus.ptr_a_inc = inc_s;
    assign bus.ptr_b_inc = inc_s;
    assign bus.addr_sel  = addr_sel_s;
    assign bus.mem_req   = req_s;
    assign bus.mem_we    = we_s;
    assign bus.mem_wdata = rdata_r;
    assign bus.busy      = busy_s;
    assign bus.done      = done_s;
    assign bus.error     = timeout_s && !bus.abort;
    assign bus.remaining = rem_val_s;

endmodule
